dcache_mshr: RTL and testbench
==============================

// Module: dcache_mshr
// PURPOSE
//  Miss Status Holding Register file for the D-cache. It records load/store line misses from Dcache
//  lookup and merges duplicate misses to the same line. It issues one memory request per line
//  through the arbiter, matches returning memory tags, and hands completed lines back to Dcache
//  as fills, in allocation order.
// PARAMETERS
//  NUM_ENTRIES  4   MSHR entries; power of 2, >=2
//  ADDR_BITS    29  block (line) address width (byte addr >> 3)
//  TAG_BITS     4   memory transaction tag width; tag 0 = "no tag / invalid"
//  BLOCK_BITS   64  cache line data width
// PORTS
//  clock          in   1                 system clock, all state on rising edge
//  reset          in   1                 asynchronous, active-high; clears all entries
//  miss_valid     in   1                 Dcache reports a line miss this cycle
//  miss_addr      in   ADDR_BITS         block address of the miss
//  miss_ready     out  1                 miss accepted (allocated or merged) this cycle
//  mem_req_valid  out  1                 request to arbiter pending
//  mem_req_addr   out  ADDR_BITS         block address of pending request
//  mem_req_accepted in 1                 arbiter forwarded request to memory this cycle
//  current_req_tag in  TAG_BITS          tag memory assigned to the forwarded request (0 = refused)
//  mem_data       in   BLOCK_BITS        returning line data
//  mem_data_tag   in   TAG_BITS          tag of returning data (0 = nothing returning)
//  fill_valid     out  1                 one-cycle pulse: write fill_data into Dcache
//  fill_addr      out  ADDR_BITS         block address of the fill
//  fill_data      out  BLOCK_BITS        line data of the fill
//  count          out  $clog2(NUM_ENTRIES+1) live entries
// BEHAVIOUR
//  Entry state: FREE -> PENDING -> WAIT -> DONE -> FREE.
//  Entries form a circular FIFO: head_ptr (oldest) and tail_ptr (next alloc), each log2(N) bits.
//  Pointers wrap N-1 -> 0. count distinguishes full from empty.
//  Reset (async): all entries FREE, head=tail=0, count=0; all outputs 0.
//  Alloc: all decisions use state at the start of the cycle.
//   - miss_valid & addr equals a non-FREE entry's addr -> merge: miss_ready=1, no alloc.
//     This includes an entry being filled this cycle.
//   - else miss_valid & count<N -> miss_ready=1; entry[tail]=PENDING, addr latched; tail++.
//   - else miss_ready=0. Dcache holds the miss and retries.
//   - miss_ready is combinational from miss_valid, miss_addr and registered state.
//   - A full MSHR does not accept a new line in the same cycle that a fill frees a slot.
//  Issue: the oldest PENDING entry (scan from head) drives mem_req_valid=1 and mem_req_addr.
//   - mem_req_accepted & current_req_tag!=0 -> entry becomes WAIT and stores the tag next edge.
//   - accepted with tag 0, or not accepted -> entry stays PENDING; the same request is held stable.
//   - At most one request is issued per cycle.
//  Return: mem_data_tag!=0 matching a WAIT entry's tag -> that entry becomes DONE and latches mem_data.
//   - Matching is out of order; if several entries match, the oldest from head wins.
//   - A nonzero tag matching no WAIT entry is ignored.
//   - A tag assigned this cycle cannot match data returning this cycle.
//  Fill: registered outputs.
//   - If entry[head] is DONE at the edge: fill_valid=1 next cycle with its addr/data; entry goes FREE; head++.
//   - Fill is strictly in allocation order. A DONE non-head entry waits for all older entries.
//   - Dcache always accepts a fill; there is no back-pressure.
//   - fill_valid drops to 0 the cycle after unless the new head is also DONE, giving back-to-back fills.
//  count: +1 on alloc, -1 on fill free, unchanged when both occur in one cycle.
//  Reset mid-operation discards all outstanding misses. Late mem_data_tag values after reset are ignored.
// TESTING
//  1. Single miss:
//     - miss 0x100 -> miss_ready=1 -> mem_req 0x100; accepted, tag 3 -> mem_data_tag=3, data=D
//     - -> next cycle fill_valid=1, addr 0x100, data D; count 1 -> 0.
//  2. Merge: miss 0x100 twice on consecutive cycles -> count=1, exactly one mem_req; second miss_ready=1.
//  3. Full:
//     - 4 distinct misses -> count=4; 5th miss 0x500 -> miss_ready=0 until the first fill frees a slot
//     - -> then accepted; tail wraps to 0.
//  4. Out-of-order return:
//     - A tag 1, B tag 2; tag 2 returns first -> no fill; tag 1 returns
//     - -> fill A, then fill B on the next cycle, back-to-back.
//  5. Refused request:
//     - current_req_tag=0 with accepted=1 -> entry stays PENDING, same mem_req_addr re-presented
//     - next cycle tag 5 -> WAIT.
//  6. Async reset asserted while 2 entries WAIT -> outputs 0 immediately; stale tag return after release -> no fill.

Source files
------------

// File: rtl/dcache_mshr.sv
// MSHR file: merges duplicate line misses, issues one memory request per line, fills in allocation order.
// Fill is registered (one cycle after the DONE head is seen); misses back-pressured by miss_ready_o only when full.
module dcache_mshr #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_BITS   = 29,
  parameter int TAG_BITS    = 4,
  parameter int BLOCK_BITS  = 64,
  localparam int PTR_BITS   = $clog2(NUM_ENTRIES),
  localparam int CNT_BITS   = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_i,
  input  logic [ADDR_BITS-1:0]  miss_addr_i,
  output logic                  miss_ready_o,
  output logic                  mem_req_valid_o,
  output logic [ADDR_BITS-1:0]  mem_req_addr_o,
  input  logic                  mem_req_accepted_i,
  input  logic [TAG_BITS-1:0]   current_req_tag_i,
  input  logic [BLOCK_BITS-1:0] mem_data_i,
  input  logic [TAG_BITS-1:0]   mem_data_tag_i,
  output logic                  fill_valid_o,
  output logic [ADDR_BITS-1:0]  fill_addr_o,
  output logic [BLOCK_BITS-1:0] fill_data_o,
  output logic [CNT_BITS-1:0]   count_o
);

  typedef enum logic [1:0] {E_FREE, E_PENDING, E_WAIT, E_DONE} ent_state_e;

  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(NUM_ENTRIES);

  ent_state_e            state_q [NUM_ENTRIES];
  ent_state_e            state_d [NUM_ENTRIES];
  logic [ADDR_BITS-1:0]  addr_q  [NUM_ENTRIES];
  logic [TAG_BITS-1:0]   tag_q   [NUM_ENTRIES];
  logic [BLOCK_BITS-1:0] data_q  [NUM_ENTRIES];
  logic [PTR_BITS-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic                  fill_vld_q;
  logic [ADDR_BITS-1:0]  fill_addr_q;
  logic [BLOCK_BITS-1:0] fill_data_q;

  logic                  hit, alloc, fill_go, issue_go;
  logic                  req_found, ret_found;
  logic [PTR_BITS-1:0]   req_idx, ret_idx, scan_a, scan_b;

  always_comb begin
    hit       = 1'b0;
    req_found = 1'b0;
    ret_found = 1'b0;
    req_idx   = '0;
    ret_idx   = '0;
    scan_a    = '0;
    scan_b    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] != E_FREE && addr_q[i] == miss_addr_i) hit = 1'b1;
    end
    // Both scans walk from the head so the oldest candidate wins.
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      scan_a = head_q + PTR_BITS'(i);
      if (!req_found && state_q[scan_a] == E_PENDING) begin
        req_found = 1'b1;
        req_idx   = scan_a;
      end
      scan_b = head_q + PTR_BITS'(i);
      if (!ret_found && mem_data_tag_i != '0 && state_q[scan_b] == E_WAIT &&
          tag_q[scan_b] == mem_data_tag_i) begin
        ret_found = 1'b1;
        ret_idx   = scan_b;
      end
    end
    alloc    = miss_valid_i && !hit && (count_q != FULL_CNT);
    fill_go  = (state_q[head_q] == E_DONE);
    issue_go = req_found && mem_req_accepted_i && (current_req_tag_i != '0);
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) state_d[i] = state_q[i];
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc) begin
      state_d[tail_q] = E_PENDING;
      tail_d          = tail_q + PTR_BITS'(1);
    end
    if (issue_go)  state_d[req_idx] = E_WAIT;
    if (ret_found) state_d[ret_idx] = E_DONE;
    if (fill_go) begin
      state_d[head_q] = E_FREE;
      head_d          = head_q + PTR_BITS'(1);
    end
    if (alloc && !fill_go)      count_d = count_q + CNT_BITS'(1);
    else if (!alloc && fill_go) count_d = count_q - CNT_BITS'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= E_FREE;
        addr_q[i]  <= '0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fill_vld_q  <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= state_d[i];
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fill_vld_q <= fill_go;
      if (alloc)     addr_q[tail_q]  <= miss_addr_i;
      if (issue_go)  tag_q[req_idx]  <= current_req_tag_i;
      if (ret_found) data_q[ret_idx] <= mem_data_i;
      if (fill_go) begin
        fill_addr_q <= addr_q[head_q];
        fill_data_q <= data_q[head_q];
      end
    end
  end

  assign miss_ready_o    = !rst_i && miss_valid_i && (hit || count_q != FULL_CNT);
  assign mem_req_valid_o = req_found;
  assign mem_req_addr_o  = req_found ? addr_q[req_idx] : '0;
  assign fill_valid_o    = fill_vld_q;
  assign fill_addr_o     = fill_addr_q;
  assign fill_data_o     = fill_data_q;
  assign count_o         = count_q;

endmodule

// File: tb/tb_dcache_mshr.sv
// Randomized + directed bench for dcache_mshr; an ordered list of outstanding lines predicts every response.
module tb_dcache_mshr;
  localparam int N = 4;
  localparam int ST_PEND = 0, ST_WAIT = 1, ST_DONE = 2;

  typedef struct {
    logic [28:0] addr;
    int          st;
    logic [3:0]  tag;
    logic [63:0] data;
  } line_t;

  typedef struct {
    logic [28:0] addr;
    logic [63:0] data;
  } fill_t;

  logic        clk = 0, rst = 1;
  logic        miss_valid = 0, miss_ready;
  logic [28:0] miss_addr = '0;
  logic        mem_req_valid, mem_req_accepted = 0;
  logic [28:0] mem_req_addr;
  logic [3:0]  current_req_tag = '0, mem_data_tag = '0;
  logic [63:0] mem_data = '0;
  logic        fill_valid;
  logic [28:0] fill_addr;
  logic [63:0] fill_data;
  logic [2:0]  count;

  int checks = 0, failures = 0;
  line_t mq[$];
  fill_t exp_q[$];

  dcache_mshr dut (
    .clk_i(clk), .rst_i(rst),
    .miss_valid_i(miss_valid), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready),
    .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr),
    .mem_req_accepted_i(mem_req_accepted), .current_req_tag_i(current_req_tag),
    .mem_data_i(mem_data), .mem_data_tag_i(mem_data_tag),
    .fill_valid_o(fill_valid), .fill_addr_o(fill_addr), .fill_data_o(fill_data),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every fill the DUT presents must be the next one predicted.
  always @(negedge clk) begin
    if (!rst && fill_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fill_unexpected: got addr %0h expected no fill at %0t", fill_addr, $time);
      end else begin
        fill_t f;
        f = exp_q.pop_front();
        chk("fill_addr", 64'(fill_addr), 64'(f.addr));
        chk("fill_data", fill_data, f.data);
      end
    end
  end

  function automatic logic [3:0] pick_wait_tag(input bit oldest);
    int idx[$];
    foreach (mq[i]) if (mq[i].st == ST_WAIT) idx.push_back(i);
    if (idx.size() == 0) return 4'd0;
    if (oldest) return mq[idx[0]].tag;
    return mq[idx[$urandom_range(0, idx.size() - 1)]].tag;
  endfunction

  task automatic cycle(input logic mv, input logic [28:0] ma, input logic acc,
                       input logic [3:0] rtag, input logic [3:0] dtag, input logic [63:0] dat);
    bit hit, exp_rdy, fill, do_alloc;
    int ii, ri;
    @(negedge clk);
    miss_valid = mv; miss_addr = ma; mem_req_accepted = acc;
    current_req_tag = rtag; mem_data_tag = dtag; mem_data = dat;
    #1;
    hit = 0;
    foreach (mq[i]) if (mq[i].addr == ma) hit = 1;
    exp_rdy  = mv && (hit || mq.size() < N);
    do_alloc = mv && !hit && mq.size() < N;
    chk("miss_ready", 64'(miss_ready), 64'(exp_rdy));
    ii = -1;
    foreach (mq[i]) if (ii < 0 && mq[i].st == ST_PEND) ii = i;
    chk("mem_req_valid", 64'(mem_req_valid), 64'(ii >= 0));
    if (ii >= 0) chk("mem_req_addr", 64'(mem_req_addr), 64'(mq[ii].addr));
    chk("count", 64'(count), 64'(mq.size()));
    ri = -1;
    if (dtag != 0) foreach (mq[i]) if (ri < 0 && mq[i].st == ST_WAIT && mq[i].tag == dtag) ri = i;
    fill = mq.size() > 0 && mq[0].st == ST_DONE;
    if (ii >= 0 && acc && rtag != 0) begin mq[ii].st = ST_WAIT; mq[ii].tag = rtag; end
    if (ri >= 0) begin mq[ri].st = ST_DONE; mq[ri].data = dat; end
    if (fill) begin
      fill_t f;
      f.addr = mq[0].addr; f.data = mq[0].data;
      exp_q.push_back(f);
      void'(mq.pop_front());
    end
    if (do_alloc) begin
      line_t l;
      l.addr = ma; l.st = ST_PEND; l.tag = 0; l.data = 0;
      mq.push_back(l);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, 0, 0, 0, '0);
  endtask

  task automatic drain();
    int guard = 0;
    while (mq.size() > 0 && guard < 300) begin
      cycle(0, '0, 1, 4'($urandom_range(1, 15)), pick_wait_tag(1), {$urandom, $urandom});
      guard++;
    end
    checks++;
    if (mq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d lines outstanding expected 0", mq.size());
    end
    idle(2);
  endtask

  initial begin
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_req_valid", 64'(mem_req_valid), 0);
    chk("rst_fill_valid", 64'(fill_valid), 0);
    chk("rst_miss_ready", 64'(miss_ready), 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Single miss through to fill.
    cycle(1, 29'h100, 0, 0, 0, '0);
    cycle(0, '0, 1, 4'd3, 0, '0);
    cycle(0, '0, 0, 0, 4'd3, 64'hD00D_CAFE_1234_5678);
    idle(2);

    // Merge on consecutive cycles.
    cycle(1, 29'h100, 0, 0, 0, '0);
    cycle(1, 29'h100, 0, 0, 0, '0);
    cycle(0, '0, 0, 0, 0, '0);
    drain();

    // Full, then fifth miss blocked until a fill frees a slot (tail wraps).
    cycle(1, 29'h100, 0, 0, 0, '0);
    cycle(1, 29'h200, 0, 0, 0, '0);
    cycle(1, 29'h300, 0, 0, 0, '0);
    cycle(1, 29'h400, 0, 0, 0, '0);
    cycle(1, 29'h500, 1, 4'd1, 0, '0);
    cycle(1, 29'h500, 0, 0, 4'd1, 64'h1111);
    cycle(1, 29'h500, 0, 0, 0, '0);
    cycle(1, 29'h500, 0, 0, 0, '0);
    drain();

    // Out-of-order return gives back-to-back fills.
    cycle(1, 29'hA00, 0, 0, 0, '0);
    cycle(1, 29'hB00, 1, 4'd1, 0, '0);
    cycle(0, '0, 1, 4'd2, 0, '0);
    cycle(0, '0, 0, 0, 4'd2, 64'hBBBB);
    cycle(0, '0, 0, 0, 0, '0);
    cycle(0, '0, 0, 0, 4'd1, 64'hAAAA);
    idle(3);

    // Refused request held, then accepted.
    cycle(1, 29'hC00, 0, 0, 0, '0);
    cycle(0, '0, 1, 4'd0, 0, '0);
    cycle(0, '0, 1, 4'd5, 0, '0);
    cycle(0, '0, 0, 0, 4'd5, 64'h5555);
    idle(2);

    // Async reset with two lines waiting; stale tags afterwards must not fill.
    cycle(1, 29'h600, 0, 0, 0, '0);
    cycle(1, 29'h700, 1, 4'd6, 0, '0);
    cycle(0, '0, 1, 4'd7, 0, '0);
    @(negedge clk);
    miss_valid = 0; mem_req_accepted = 0; mem_data_tag = 0;
    #2 rst = 1;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_req_valid", 64'(mem_req_valid), 0);
    chk("arst_fill_valid", 64'(fill_valid), 0);
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    cycle(0, '0, 0, 0, 4'd6, 64'hDEAD);
    cycle(0, '0, 0, 0, 4'd7, 64'hBEEF);
    idle(2);

    // Random traffic over a small address pool to exercise merges and full.
    for (int k = 0; k < 1500; k++) begin
      logic mv, acc;
      logic [3:0] rtag, dtag;
      int r;
      mv   = ($urandom % 3) != 0;
      acc  = $urandom % 2;
      rtag = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      r    = $urandom % 10;
      dtag = (r < 5) ? pick_wait_tag(0) : (r < 6) ? 4'($urandom_range(1, 15)) : 4'd0;
      cycle(mv, 29'h100 + 29'($urandom % 6), acc, rtag, dtag, {$urandom, $urandom});
    end
    drain();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL fill_missing: got %0d fills unseen expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
